// File: rtl/hdr_pkg.sv
// Shared types for the HDR exposure-pair sequencer: FSM states, error causes,
// per-beat control flags and the beat classification rule.
package hdr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HUNT,
    ST_STREAM,
    ST_ABORT
  } seq_state_e;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_SOP_IN_FRAME,
    ERR_EOP_SKEW,
    ERR_EOP_EARLY,
    ERR_EOP_MISSING
  } err_cause_e;

  typedef struct packed {
    logic sop;
    logic eop;
    logic done;
    logic err;
  } beat_ctl_t;

  // Classify one paired beat; at_last means this beat is the frame's final index.
  function automatic err_cause_e classify_beat(
    input logic in_frame,
    input logic sop0,
    input logic sop1,
    input logic eop0,
    input logic eop1,
    input logic at_last
  );
    if (in_frame && (sop0 || sop1)) return ERR_SOP_IN_FRAME;
    if (eop0 != eop1)               return ERR_EOP_SKEW;
    if (eop0 && !at_last)           return ERR_EOP_EARLY;
    if (!eop0 && at_last)           return ERR_EOP_MISSING;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/hdr_pair_out_reg.sv
// Registered output stage: presents each paired transfer one cycle later,
// with frame_done/frame_err pulses aligned to the beat.
module hdr_pair_out_reg
  import hdr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  xfer_i,
  input  beat_ctl_t             ctl_i,
  input  logic [DATA_WIDTH-1:0] data0_i,
  input  logic [DATA_WIDTH-1:0] data1_i,
  output logic                  valid_o,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic [DATA_WIDTH-1:0] data0_o,
  output logic [DATA_WIDTH-1:0] data1_o,
  output logic                  done_o,
  output logic                  err_o
);

  logic                  r_valid;
  beat_ctl_t             r_ctl;
  logic [DATA_WIDTH-1:0] r_data0;
  logic [DATA_WIDTH-1:0] r_data1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_ctl   <= '0;
      r_data0 <= '0;
      r_data1 <= '0;
    end else begin
      r_valid <= xfer_i;
      r_ctl   <= xfer_i ? ctl_i : '0;
      if (xfer_i) begin
        r_data0 <= data0_i;
        r_data1 <= data1_i;
      end
    end
  end

  assign valid_o = r_valid;
  assign sop_o   = r_ctl.sop;
  assign eop_o   = r_ctl.eop;
  assign done_o  = r_ctl.done;
  assign err_o   = r_ctl.err;
  assign data0_o = r_data0;
  assign data1_o = r_data1;

endmodule

// File: rtl/hdr_pair_sequencer.sv
// Aligns two exposure streams frame-by-frame into lock-step beat pairs for the
// HDR merge, dropping pre-SOP debris and aborting frames with broken framing.
module hdr_pair_sequencer
  import hdr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FRAME_PIXELS = 2073600
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable_i,
  input  logic                  err_clr_i,
  input  logic                  asi_snk_0_valid_i,
  input  logic                  asi_snk_0_startofpacket_i,
  input  logic                  asi_snk_0_endofpacket_i,
  input  logic [DATA_WIDTH-1:0] asi_snk_0_data_i,
  output logic                  asi_snk_0_ready_o,
  input  logic                  asi_snk_1_valid_i,
  input  logic                  asi_snk_1_startofpacket_i,
  input  logic                  asi_snk_1_endofpacket_i,
  input  logic [DATA_WIDTH-1:0] asi_snk_1_data_i,
  output logic                  asi_snk_1_ready_o,
  output logic                  aso_src_valid_o,
  output logic                  aso_src_startofpacket_o,
  output logic                  aso_src_endofpacket_o,
  output logic [DATA_WIDTH-1:0] aso_src_data0_o,
  output logic [DATA_WIDTH-1:0] aso_src_data1_o,
  output logic                  frame_done_o,
  output logic                  frame_err_o,
  output logic                  err_sticky_o
);

  localparam int unsigned      CNT_W    = $clog2(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_idx;
  logic             r_err_sticky;
  logic             w_rdy0;
  logic             w_rdy1;
  logic             w_xfer;
  logic             w_both_sop;
  logic             w_both_valid;
  logic             w_at_last;
  err_cause_e       w_cause;
  beat_ctl_t        w_ctl;

  assign w_both_valid = asi_snk_0_valid_i & asi_snk_1_valid_i;
  assign w_both_sop   = w_both_valid & asi_snk_0_startofpacket_i & asi_snk_1_startofpacket_i;
  // The SOP pair taken in HUNT is beat 0; in STREAM the counter is the beat index.
  assign w_idx        = (r_state == ST_STREAM) ? r_cnt : '0;
  assign w_at_last    = (w_idx == LAST_IDX);
  assign w_cause      = classify_beat(r_state == ST_STREAM,
                                      asi_snk_0_startofpacket_i, asi_snk_1_startofpacket_i,
                                      asi_snk_0_endofpacket_i, asi_snk_1_endofpacket_i,
                                      w_at_last);

  // Next-state, ready and per-beat control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rdy0      = 1'b0;
    w_rdy1      = 1'b0;
    w_xfer      = 1'b0;
    w_ctl       = '0;
    case (r_state)
      ST_IDLE: begin
        if (enable_i) w_state_nxt = ST_HUNT;
      end
      ST_HUNT: begin
        if (!enable_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_both_sop) begin
          w_rdy0 = 1'b1;
          w_rdy1 = 1'b1;
          w_xfer = 1'b1;
        end else begin
          w_rdy0 = asi_snk_0_valid_i & ~asi_snk_0_startofpacket_i;
          w_rdy1 = asi_snk_1_valid_i & ~asi_snk_1_startofpacket_i;
        end
      end
      ST_STREAM: begin
        w_rdy0 = w_both_valid;
        w_rdy1 = w_both_valid;
        w_xfer = w_both_valid;
      end
      ST_ABORT: begin
        w_state_nxt = ST_HUNT;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_xfer) begin
      w_ctl.sop = (r_state == ST_HUNT);
      if (w_cause != ERR_NONE) begin
        w_ctl.eop   = 1'b1;
        w_ctl.err   = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_ABORT;
      end else if (w_at_last) begin
        w_ctl.eop   = 1'b1;
        w_ctl.done  = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = enable_i ? ST_HUNT : ST_IDLE;
      end else begin
        w_cnt_nxt   = w_idx + CNT_W'(1);
        w_state_nxt = ST_STREAM;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      // A new error in the same cycle as a clear wins.
      if (w_ctl.err)      r_err_sticky <= 1'b1;
      else if (err_clr_i) r_err_sticky <= 1'b0;
    end
  end

  assign asi_snk_0_ready_o = w_rdy0;
  assign asi_snk_1_ready_o = w_rdy1;
  assign err_sticky_o      = r_err_sticky;

  hdr_pair_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .xfer_i  (w_xfer),
    .ctl_i   (w_ctl),
    .data0_i (asi_snk_0_data_i),
    .data1_i (asi_snk_1_data_i),
    .valid_o (aso_src_valid_o),
    .sop_o   (aso_src_startofpacket_o),
    .eop_o   (aso_src_endofpacket_o),
    .data0_o (aso_src_data0_o),
    .data1_o (aso_src_data1_o),
    .done_o  (frame_done_o),
    .err_o   (frame_err_o)
  );

endmodule

// File: doc/hdr_pair_sequencer.md
HDR_PAIR_SEQUENCER -- requirements
Module: hdr_pair_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, pixel word width of each exposure stream.
REQ-002 SHALL have parameter FRAME_PIXELS, default 2073600, beats per frame (SOP beat through EOP beat inclusive).
REQ-003 SHALL have localparam CNT_W = $clog2(FRAME_PIXELS), pixel counter width.
REQ-004 Ports SHALL be:
clk  in  1  single clock for all logic
reset_n  in  1  asynchronous, active-low reset
enable_i  in  1  level: permit starting new frames
err_clr_i  in  1  pulse: clear sticky error
asi_snk_0_valid_i / _startofpacket_i / _endofpacket_i  in  1 each  exposure-0 stream control
asi_snk_0_data_i  in  DATA_WIDTH  exposure-0 pixel
asi_snk_0_ready_o  out  1  exposure-0 accept
asi_snk_1_valid_i / _startofpacket_i / _endofpacket_i  in  1 each  exposure-1 stream control
asi_snk_1_data_i  in  DATA_WIDTH  exposure-1 pixel
asi_snk_1_ready_o  out  1  exposure-1 accept
aso_src_valid_o / _startofpacket_o / _endofpacket_o  out  1 each  paired-beat control to HDR merge
aso_src_data0_o, aso_src_data1_o  out  DATA_WIDTH each  paired exposure-0/1 pixels
frame_done_o  out  1  one-cycle pulse per correct frame
frame_err_o  out  1  one-cycle pulse per aborted frame
err_sticky_o  out  1  latched error flag

Function
REQ-005 A beat on input k SHALL transfer when asi_snk_k_valid_i & asi_snk_k_ready_o are both high in the same cycle.
REQ-006 FSM states SHALL be IDLE, HUNT, STREAM, ABORT.
REQ-007 IDLE: both ready low; go to HUNT when enable_i = 1.
REQ-008 HUNT: ready_k high while input k is valid with SOP low (non-SOP beats discarded per input independently); ready_k low once input k holds a valid SOP beat.
REQ-009 HUNT: when both inputs hold valid SOP beats, both readies SHALL go high that cycle (paired transfer), counter = 1, state -> STREAM; if enable_i = 0, state -> IDLE instead of pairing.
REQ-010 STREAM: asi_snk_0_ready_o = asi_snk_1_ready_o = v0 & v1; no single-sided transfer SHALL occur.
REQ-011 Every paired transfer SHALL appear on aso_src_* exactly 1 cycle later (registered), with data0/data1 from inputs 0/1 and SOP asserted only on the frame's first beat.
REQ-012 Counter SHALL increment per paired transfer in STREAM and never wrap; legal EOP is when both EOPs are high and counter == FRAME_PIXELS-1.
REQ-013 Legal EOP: output EOP on that beat, frame_done_o pulses with the output beat, counter cleared, state -> HUNT (or IDLE if enable_i = 0).
REQ-014 Error beat = either SOP high in STREAM, EOP on one input only, EOP at wrong count, or counter == FRAME_PIXELS-1 without both EOPs; that beat SHALL still be consumed and output with EOP forced high.
REQ-015 On error beat: frame_err_o pulses with the output beat, err_sticky_o sets, state -> ABORT.
REQ-016 ABORT: both ready low for one cycle, then -> HUNT.
REQ-017 enable_i falling in STREAM SHALL NOT truncate the frame; FSM returns to IDLE after the frame ends.
REQ-018 err_sticky_o SHALL clear on err_clr_i; a simultaneous new error SHALL take priority (stays 1).
REQ-019 aso_src_valid_o SHALL be low in every cycle without a transfer in the previous cycle.

Reset
REQ-020 reset_n low SHALL asynchronously force state IDLE, counter 0, and every output (readies, aso_src_*, data, frame_done_o, frame_err_o, err_sticky_o) to 0.
REQ-021 Reset asserted mid-frame SHALL discard the frame; after release the block restarts by hunting a new SOP pair.

Structure
REQ-022 State enum and error-cause encodings SHALL live in shared package hdr_pkg.
REQ-023 Output register stage SHALL be a sub-module hdr_pair_out_reg; FSM and counter stay in the top.

Verification (FRAME_PIXELS = 16)
REQ-024 Both streams send aligned 16-beat frames, data0 = i, data1 = 100+i -> 16 output beats, pairs (i, 100+i), SOP on beat 0, EOP on beat 15, one frame_done_o pulse.
REQ-025 Input 1 sends 3 stray non-SOP beats before SOP -> strays dropped, output frame still starts with pair (0, 100).
REQ-026 Input 0 valid toggles every other cycle -> no transfer when v0 = 0, output still 16 correctly paired beats.
REQ-027 Input 0 EOP at beat 9 -> output beat 9 carries EOP, frame_err_o pulse, err_sticky_o = 1 until err_clr_i.
REQ-028 reset_n low at beat 7 -> all outputs 0 immediately; next aligned frame after release output complete with SOP.
REQ-029 enable_i dropped at beat 4 -> frame completes with 16 beats, then readies stay 0 in IDLE.
